// File: rtl/mii_pkg.sv
// Shared definitions for the MII/GMII receive framer.
//   state_t      : framer FSM states
//   PRE_*/SFD_*  : preamble and start-of-frame delimiter patterns
//   ERR_*        : bit positions within the err output
package mii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  localparam logic [3:0] PRE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB  = 4'hD;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam int ERR_RXER = 0;
  localparam int ERR_ODD  = 1;
  localparam int ERR_LEN  = 2;

endpackage

// File: rtl/mii_byte_assembler.sv
// Byte assembler for the receive path.
// IN_W=4 pairs nibbles (low nibble first) into bytes; IN_W=8 passes bytes through.
// Ports:
//   mii_clk, reset_n : clock, synchronous active-low reset
//   en               : sample valid
//   d                : input nibble/byte
//   clear            : forces phase back to the low nibble (overrides en)
//   byte_data        : assembled byte (combinational, valid with byte_vld)
//   byte_vld         : byte_data completes on this sample
//   phase            : 1 when a low nibble is held awaiting its high nibble
module mii_byte_assembler #(
  parameter int IN_W = 4
) (
  input  logic            mii_clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [IN_W-1:0] d,
  input  logic            clear,
  output logic [7:0]      byte_data,
  output logic            byte_vld,
  output logic            phase
);

  // In byte mode phase never leaves 0, so a frame can never end "odd".
  always_ff @(posedge mii_clk) begin
    if (!reset_n || clear) begin
      phase <= 1'b0;
    end else if (en) begin
      phase <= (IN_W == 4) ? ~phase : 1'b0;
    end
  end

  generate
    if (IN_W == 4) begin : g_nibble
      logic [3:0] low_nib;

      always_ff @(posedge mii_clk) begin
        if (!reset_n) begin
          low_nib <= '0;
        end else if (en && !phase) begin
          low_nib <= d;
        end
      end

      always_comb begin
        byte_data = {d, low_nib};
        byte_vld  = en && phase && !clear;
      end
    end else begin : g_byte
      always_comb begin
        byte_data = d;
        byte_vld  = en && !clear;
      end
    end
  endgenerate

endmodule

// File: rtl/mii_rx_framer.sv
// Receive framer for MII (IN_W=4) / GMII (IN_W=8).
// Strips preamble/SFD, emits payload bytes with sof, and reports length and
// error status with a one-cycle eof pulse after the frame ends.
// Ports:
//   mii_clk, reset_n : receive clock, synchronous active-low reset
//   mii_en, mii_er   : RX_DV, RX_ER
//   mii_d            : receive nibble/byte
//   q, rdy, sof      : payload byte, byte strobe, first-byte marker
//   eof, len, err    : frame-end pulse; len/err valid at eof, held until next sof
module mii_rx_framer
  import mii_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             mii_clk,
  input  logic             reset_n,
  input  logic             mii_en,
  input  logic             mii_er,
  input  logic [IN_W-1:0]  mii_d,
  output logic [7:0]       q,
  output logic             rdy,
  output logic             sof,
  output logic             eof,
  output logic [LEN_W-1:0] len,
  output logic [2:0]       err
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t state, state_nxt;

  logic [7:0]       d8;
  logic             is_pre, is_sfd;
  logic             asm_en, asm_clear, asm_vld, asm_phase;
  logic [7:0]       asm_byte;
  logic [LEN_W-1:0] cnt;
  logic             rxer_seen, ovf_seen;
  logic [2:0]       err_nxt;

  // Preamble classification of the current sample. Being in PREAMBLE already
  // implies at least one preamble nibble was seen, which qualifies SFD_NIB.
  always_comb begin
    d8 = 8'(mii_d);
    if (IN_W == 4) begin
      is_pre = (d8 == 8'(PRE_NIB));
      is_sfd = (d8 == 8'(SFD_NIB)) && (state == PREAMBLE);
    end else begin
      is_pre = (d8 == PRE_BYTE);
      is_sfd = (d8 == SFD_BYTE);
    end
  end

  always_ff @(posedge mii_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, PREAMBLE: begin
        if (!mii_en)     state_nxt = IDLE;
        else if (is_pre) state_nxt = PREAMBLE;
        else if (is_sfd) state_nxt = DATA;
        else             state_nxt = DROP;
      end
      DATA, DROP: begin
        if (!mii_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    asm_en    = mii_en && (state == DATA);
    asm_clear = (state != DATA);
  end

  mii_byte_assembler #(
    .IN_W(IN_W)
  ) u_asm (
    .mii_clk  (mii_clk),
    .reset_n  (reset_n),
    .en       (asm_en),
    .d        (mii_d),
    .clear    (asm_clear),
    .byte_data(asm_byte),
    .byte_vld (asm_vld),
    .phase    (asm_phase)
  );

  always_comb begin
    err_nxt           = '0;
    err_nxt[ERR_RXER] = rxer_seen;
    err_nxt[ERR_ODD]  = asm_phase;
    err_nxt[ERR_LEN]  = ovf_seen || (cnt < MIN_L);
  end

  always_ff @(posedge mii_clk) begin
    if (!reset_n) begin
      q         <= '0;
      rdy       <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      len       <= '0;
      err       <= '0;
      cnt       <= '0;
      rxer_seen <= 1'b0;
      ovf_seen  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
      if (state != DATA) begin
        cnt       <= '0;
        rxer_seen <= 1'b0;
        ovf_seen  <= 1'b0;
      end else if (mii_en) begin
        if (mii_er) rxer_seen <= 1'b1;
        if (asm_vld) begin
          if (cnt < MAX_L) begin
            q   <= asm_byte;
            rdy <= 1'b1;
            cnt <= cnt + LEN_W'(1);
            if (cnt == '0) begin
              sof <= 1'b1;
              len <= '0;
              err <= '0;
            end
          end else begin
            ovf_seen <= 1'b1;
          end
        end
      end else if (cnt != '0) begin
        // A frame that ended before its first byte never raised sof, so it
        // gets no eof either.
        eof <= 1'b1;
        len <= cnt;
        err <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
module tb_mii_rx_framer;

  logic        clk, rst_n;
  logic        en4, er4, en8, er8;
  logic [3:0]  d4;
  logic [7:0]  d8;
  logic [7:0]  q4, q8;
  logic        rdy4, sof4, eof4, rdy8, sof8, eof8;
  logic [10:0] len4, len8;
  logic [2:0]  err4, err8;

  mii_rx_framer #(.IN_W(4)) dut4 (
    .mii_clk(clk), .reset_n(rst_n), .mii_en(en4), .mii_er(er4), .mii_d(d4),
    .q(q4), .rdy(rdy4), .sof(sof4), .eof(eof4), .len(len4), .err(err4)
  );

  mii_rx_framer #(.IN_W(8)) dut8 (
    .mii_clk(clk), .reset_n(rst_n), .mii_en(en8), .mii_er(er8), .mii_d(d8),
    .q(q8), .rdy(rdy8), .sof(sof8), .eof(eof8), .len(len8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  log4[$], log8[$];
  logic [10:0] len8_q[$];
  int sof4_n, sof8_n, eof4_n, eof8_n, ovl4, ovl8;
  int eof_cyc4, eof_cyc8, fall4, fall8, first8, last8;
  logic [7:0] sofb4, sofb8;

  always @(negedge clk) begin
    if (rdy4) log4.push_back(q4);
    if (sof4) begin sof4_n++; sofb4 = q4; end
    if (eof4) begin eof4_n++; eof_cyc4 = cyc; if (rdy4) ovl4++; end
    if (rdy8) begin
      log8.push_back(q8);
      if (first8 < 0) first8 = cyc;
      last8 = cyc;
    end
    if (sof8) begin sof8_n++; sofb8 = q8; end
    if (eof8) begin eof8_n++; eof_cyc8 = cyc; len8_q.push_back(len8); if (rdy8) ovl8++; end
  end

  task automatic clear_logs();
    log4.delete(); log8.delete(); len8_q.delete();
    sof4_n = 0; sof8_n = 0; eof4_n = 0; eof8_n = 0; ovl4 = 0; ovl8 = 0;
    eof_cyc4 = -1; eof_cyc8 = -1; first8 = -1; last8 = -1;
    sofb4 = 8'hxx; sofb8 = 8'hxx;
  endtask

  task automatic nib(input logic [3:0] v);
    en4 = 1'b1; er4 = 1'b0; d4 = v;
    @(posedge clk); #1;
  endtask

  task automatic byte8(input logic [7:0] v, input logic er);
    en8 = 1'b1; er8 = er; d8 = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en4 = 1'b0; er4 = 1'b0; d4 = '0;
    en8 = 1'b0; er8 = 1'b0; d8 = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame4(input int nbytes, input bit extra_nib);
    logic [7:0] b;
    repeat (15) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i);
      nib(b[3:0]);
      nib(b[7:4]);
    end
    if (extra_nib) nib(4'h7);
    en4 = 1'b0; d4 = '0;
    @(posedge clk); #1;
    fall4 = cyc;
  endtask

  task automatic frame8(input int nbytes, input int er_idx);
    repeat (7) byte8(8'h55, 1'b0);
    byte8(8'hD5, 1'b0);
    for (int i = 0; i < nbytes; i++) byte8(8'(i), i == er_idx);
    en8 = 1'b0; er8 = 1'b0; d8 = '0;
    @(posedge clk); #1;
    fall8 = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({q4, rdy4, sof4, eof4, len4, err4} !== 25'd0)
      $display("FAIL reset_mii got %h exp 0", {q4, rdy4, sof4, eof4, len4, err4});
    else passes++;
    checks++;
    if ({q8, rdy8, sof8, eof8, len8, err8} !== 25'd0)
      $display("FAIL reset_gmii got %h exp 0", {q8, rdy8, sof8, eof8, len8, err8});
    else passes++;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_nibble_frame();
    int bad;
    clear_logs();
    frame4(64, 1'b0);
    idle(3);
    checks++;
    if (log4.size() !== 64) $display("FAIL nib_count got %0d exp 64", log4.size());
    else passes++;
    bad = -1;
    for (int i = 0; i < log4.size(); i++) if (log4[i] !== 8'(i)) begin bad = i; break; end
    checks++;
    if (bad != -1) $display("FAIL nib_data idx %0d got %h exp %h", bad, log4[bad], 8'(bad));
    else passes++;
    checks++;
    if (sof4_n !== 1 || sofb4 !== 8'h00) $display("FAIL nib_sof got n=%0d q=%h exp n=1 q=00", sof4_n, sofb4);
    else passes++;
    checks++;
    if (eof4_n !== 1) $display("FAIL nib_eof_count got %0d exp 1", eof4_n);
    else passes++;
    checks++;
    if (eof_cyc4 !== fall4) $display("FAIL nib_eof_timing got %0d exp %0d", eof_cyc4, fall4);
    else passes++;
    checks++;
    if (len4 !== 11'd64) $display("FAIL nib_len got %0d exp 64", len4);
    else passes++;
    checks++;
    if (err4 !== 3'b000) $display("FAIL nib_err got %b exp 000", err4);
    else passes++;
    checks++;
    if (ovl4 !== 0) $display("FAIL nib_eof_rdy_overlap got %0d exp 0", ovl4);
    else passes++;
  endtask

  task automatic test_nibble_odd();
    int bad;
    clear_logs();
    frame4(60, 1'b1);
    idle(3);
    checks++;
    if (log4.size() !== 60) $display("FAIL odd_count got %0d exp 60", log4.size());
    else passes++;
    bad = -1;
    for (int i = 0; i < log4.size(); i++) if (log4[i] !== 8'(i)) begin bad = i; break; end
    checks++;
    if (bad != -1) $display("FAIL odd_data idx %0d got %h exp %h", bad, log4[bad], 8'(bad));
    else passes++;
    checks++;
    if (eof4_n !== 1 || len4 !== 11'd60) $display("FAIL odd_len got n=%0d len=%0d exp n=1 len=60", eof4_n, len4);
    else passes++;
    checks++;
    if (err4 !== 3'b110) $display("FAIL odd_err got %b exp 110", err4);
    else passes++;
  endtask

  task automatic test_byte_rxer();
    int bad;
    clear_logs();
    frame8(100, 50);
    idle(3);
    checks++;
    if (log8.size() !== 100) $display("FAIL rxer_count got %0d exp 100", log8.size());
    else passes++;
    bad = -1;
    for (int i = 0; i < log8.size(); i++) if (log8[i] !== 8'(i)) begin bad = i; break; end
    checks++;
    if (bad != -1) $display("FAIL rxer_data idx %0d got %h exp %h", bad, log8[bad], 8'(bad));
    else passes++;
    checks++;
    if (last8 - first8 !== 99) $display("FAIL rxer_consecutive got span %0d exp 99", last8 - first8);
    else passes++;
    checks++;
    if (sof8_n !== 1 || sofb8 !== 8'h00) $display("FAIL rxer_sof got n=%0d q=%h exp n=1 q=00", sof8_n, sofb8);
    else passes++;
    checks++;
    if (eof8_n !== 1 || eof_cyc8 !== fall8) $display("FAIL rxer_eof got n=%0d cyc=%0d exp n=1 cyc=%0d", eof8_n, eof_cyc8, fall8);
    else passes++;
    checks++;
    if (len8 !== 11'd100) $display("FAIL rxer_len got %0d exp 100", len8);
    else passes++;
    checks++;
    if (err8 !== 3'b001) $display("FAIL rxer_err got %b exp 001", err8);
    else passes++;
  endtask

  task automatic test_hold_clear();
    idle(5);
    checks++;
    if (len8 !== 11'd100 || err8 !== 3'b001) $display("FAIL hold got len=%0d err=%b exp len=100 err=001", len8, err8);
    else passes++;
    clear_logs();
    repeat (7) byte8(8'h55, 1'b0);
    byte8(8'hD5, 1'b0);
    byte8(8'h00, 1'b0);
    byte8(8'h01, 1'b0);
    checks++;
    if (len8 !== 11'd0 || err8 !== 3'b000) $display("FAIL clear_at_sof got len=%0d err=%b exp len=0 err=000", len8, err8);
    else passes++;
    for (int i = 2; i < 64; i++) byte8(8'(i), 1'b0);
    idle(3);
    checks++;
    if (len8 !== 11'd64 || err8 !== 3'b000) $display("FAIL min_len_frame got len=%0d err=%b exp len=64 err=000", len8, err8);
    else passes++;
  endtask

  task automatic test_drop();
    clear_logs();
    byte8(8'h55, 1'b0);
    byte8(8'h55, 1'b0);
    byte8(8'hA5, 1'b0);
    for (int i = 0; i < 70; i++) byte8(8'(i), 1'b0);
    idle(3);
    checks++;
    if (log8.size() !== 0) $display("FAIL drop_rdy got %0d exp 0", log8.size());
    else passes++;
    checks++;
    if (sof8_n !== 0 || eof8_n !== 0) $display("FAIL drop_sof_eof got sof=%0d eof=%0d exp 0 0", sof8_n, eof8_n);
    else passes++;
    checks++;
    if (len8 !== 11'd64) $display("FAIL drop_len_hold got %0d exp 64", len8);
    else passes++;
    frame8(65, -1);
    idle(3);
    checks++;
    if (log8.size() !== 65 || eof8_n !== 1) $display("FAIL after_drop got n=%0d eof=%0d exp 65 1", log8.size(), eof8_n);
    else passes++;
    checks++;
    if (len8 !== 11'd65 || err8 !== 3'b000) $display("FAIL after_drop_len got len=%0d err=%b exp 65 000", len8, err8);
    else passes++;
  endtask

  task automatic test_short();
    clear_logs();
    frame8(63, -1);
    idle(3);
    checks++;
    if (log8.size() !== 63) $display("FAIL short_count got %0d exp 63", log8.size());
    else passes++;
    checks++;
    if (len8 !== 11'd63 || err8 !== 3'b100) $display("FAIL short_len got len=%0d err=%b exp 63 100", len8, err8);
    else passes++;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    frame8(64, -1);
    frame8(70, -1);
    idle(3);
    checks++;
    if (log8.size() !== 134) $display("FAIL b2b_count got %0d exp 134", log8.size());
    else passes++;
    checks++;
    if (eof8_n !== 2 || sof8_n !== 2) $display("FAIL b2b_markers got sof=%0d eof=%0d exp 2 2", sof8_n, eof8_n);
    else passes++;
    checks++;
    if (len8_q.size() !== 2 || len8_q[0] !== 11'd64 || len8_q[1] !== 11'd70)
      $display("FAIL b2b_len got n=%0d first=%0d second=%0d exp 64 70", len8_q.size(), len8_q[0], len8_q[1]);
    else passes++;
    checks++;
    if (ovl8 !== 0 || err8 !== 3'b000) $display("FAIL b2b_err got ovl=%0d err=%b exp 0 000", ovl8, err8);
    else passes++;
  endtask

  task automatic test_overlength();
    int bad;
    clear_logs();
    frame8(1600, -1);
    idle(3);
    checks++;
    if (log8.size() !== 1518) $display("FAIL ovf_count got %0d exp 1518", log8.size());
    else passes++;
    bad = -1;
    for (int i = 0; i < log8.size(); i++) if (log8[i] !== 8'(i)) begin bad = i; break; end
    checks++;
    if (bad != -1) $display("FAIL ovf_data idx %0d got %h exp %h", bad, log8[bad], 8'(bad));
    else passes++;
    checks++;
    if (eof8_n !== 1 || len8 !== 11'd1518) $display("FAIL ovf_len got n=%0d len=%0d exp 1 1518", eof8_n, len8);
    else passes++;
    checks++;
    if (err8 !== 3'b100) $display("FAIL ovf_err got %b exp 100", err8);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    repeat (7) byte8(8'h55, 1'b0);
    byte8(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) byte8(8'(i), 1'b0);
    en8 = 1'b1; d8 = 8'd20; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({q8, rdy8, sof8, eof8, len8, err8} !== 25'd0)
      $display("FAIL midreset_outputs got %h exp 0", {q8, rdy8, sof8, eof8, len8, err8});
    else passes++;
    rst_n = 1'b1;
    for (int i = 21; i < 70; i++) byte8(8'(i), 1'b0);
    idle(3);
    checks++;
    if (log8.size() !== 20 || sof8_n !== 1) $display("FAIL midreset_bytes got n=%0d sof=%0d exp 20 1", log8.size(), sof8_n);
    else passes++;
    checks++;
    if (eof8_n !== 0) $display("FAIL midreset_eof got %0d exp 0", eof8_n);
    else passes++;
    clear_logs();
    frame8(66, -1);
    idle(3);
    checks++;
    if (log8.size() !== 66 || eof8_n !== 1 || len8 !== 11'd66)
      $display("FAIL after_reset got n=%0d eof=%0d len=%0d exp 66 1 66", log8.size(), eof8_n, len8);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    en4 = 1'b0; er4 = 1'b0; d4 = '0;
    en8 = 1'b0; er8 = 1'b0; d8 = '0;
    clear_logs();
    test_reset();
    test_nibble_frame();
    test_nibble_odd();
    test_byte_rxer();
    test_hold_clear();
    test_drop();
    test_short();
    test_back_to_back();
    test_overlength();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
